// File: rtl/zeroskip_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : zeroskip_ctrl_if
//  Description : Bundle of configuration, input-stream, output-stream and
//                status signals for the zero-skip activation compactor
//                sequencer.
//                master modport : frame/layer controller + fetch + MAC side
//                slave modport  : zeroskip_ctrl
//  Ports       : cfg_start/cfg_mode/cfg_frame_len   frame configuration
//                in_valid/in_ready/in_znz/in_act    input group stream
//                out_valid/out_ready/out_act/
//                out_mask/out_nz_cnt/out_last       compacted output stream
//                busy/done/err_sticky/err_cnt       frame status
//  Revision    : 1.0  initial release
// ============================================================================
interface zeroskip_ctrl_if #(
    parameter int GROUP_SIZE   = 32,
    parameter int GROUP_NZ_MAX = 16,
    parameter int DATA_W       = 8,
    parameter int FLEN_W       = 16
);
    localparam int NZ_CNT_W = $clog2(GROUP_NZ_MAX) + 1;

    // configuration
    logic                             cfg_start;
    logic                             cfg_mode;
    logic [FLEN_W-1:0]                cfg_frame_len;

    // input group stream
    logic                             in_valid;
    logic                             in_ready;
    logic [GROUP_SIZE-1:0]            in_znz;
    logic [GROUP_SIZE*DATA_W-1:0]     in_act;

    // compacted output stream
    logic                             out_valid;
    logic                             out_ready;
    logic [GROUP_NZ_MAX*DATA_W-1:0]   out_act;
    logic [GROUP_SIZE-1:0]            out_mask;
    logic [NZ_CNT_W-1:0]              out_nz_cnt;
    logic                             out_last;

    // status
    logic                             busy;
    logic                             done;
    logic                             err_sticky;
    logic [FLEN_W-1:0]                err_cnt;

    modport master (
        output cfg_start, cfg_mode, cfg_frame_len,
        output in_valid, in_znz, in_act,
        input  in_ready,
        input  out_valid, out_act, out_mask, out_nz_cnt, out_last,
        output out_ready,
        input  busy, done, err_sticky, err_cnt
    );

    modport slave (
        input  cfg_start, cfg_mode, cfg_frame_len,
        input  in_valid, in_znz, in_act,
        output in_ready,
        output out_valid, out_act, out_mask, out_nz_cnt, out_last,
        input  out_ready,
        output busy, done, err_sticky, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/zeroskip_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : zeroskip_ctrl
//  Description : Frame-level sequencer and sparsity-rate checker. Accepts a
//                configured number of activation groups, compacts each group
//                into a dense vector of at most 'limit' non-zero lanes
//                (8:32 or 16:32 mode) and presents it through a one-deep
//                registered output stage with backpressure. Reports frame
//                completion and sparsity-limit violations.
//  Ports       : clk   clock, all state on rising edge
//                rst   asynchronous active-high reset
//                bus   zeroskip_ctrl_if.slave (config, in/out streams, status)
//  Revision    : 1.0  initial release
// ============================================================================
module zeroskip_ctrl #(
    parameter int GROUP_SIZE   = 32,
    parameter int GROUP_NZ_MAX = 16,
    parameter int DATA_W       = 8,
    parameter int FLEN_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    zeroskip_ctrl_if.slave       bus
);

    localparam int NZ_CNT_W   = $clog2(GROUP_NZ_MAX) + 1;
    localparam int POP_W      = $clog2(GROUP_SIZE) + 1;
    localparam int LANE_IDX_W = $clog2(GROUP_NZ_MAX);

    localparam logic [POP_W-1:0]  C_LIMIT_FULL = POP_W'(GROUP_NZ_MAX);
    localparam logic [POP_W-1:0]  C_LIMIT_HALF = POP_W'(GROUP_NZ_MAX / 2);
    localparam logic [FLEN_W-1:0] C_ERR_MAX    = {FLEN_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                          state_q,      state_d;
    logic                            mode_q,       mode_d;
    logic [FLEN_W-1:0]               len_q,        len_d;
    logic [FLEN_W-1:0]               grp_cnt_q,    grp_cnt_d;
    logic                            out_valid_q,  out_valid_d;
    logic [GROUP_NZ_MAX*DATA_W-1:0]  out_act_q,    out_act_d;
    logic [GROUP_SIZE-1:0]           out_mask_q,   out_mask_d;
    logic [NZ_CNT_W-1:0]             out_nz_cnt_q, out_nz_cnt_d;
    logic                            out_last_q,   out_last_d;
    logic                            done_q,       done_d;
    logic                            err_sticky_q, err_sticky_d;
    logic [FLEN_W-1:0]               err_cnt_q,    err_cnt_d;

    // ------------------------------------------------------------------------
    // Compaction datapath
    // ------------------------------------------------------------------------
    logic [POP_W-1:0]                w_limit;
    logic [POP_W-1:0]                w_popcnt;
    logic [POP_W-1:0]                w_kept;
    logic [DATA_W-1:0]               w_lane [GROUP_NZ_MAX];
    logic [GROUP_SIZE-1:0]           w_mask;
    logic [GROUP_NZ_MAX*DATA_W-1:0]  w_act;
    logic                            w_violation;

    // Priority walk from lane 0 upward: every flagged lane counts towards the
    // popcount, but only the first 'limit' of them claim an output slot.
    // w_kept never exceeds the limit, so its low bits always address a valid
    // output lane while a slot is still free.
    always_comb begin
        w_limit  = mode_q ? C_LIMIT_FULL : C_LIMIT_HALF;
        w_popcnt = '0;
        w_kept   = '0;
        w_mask   = '0;
        for (int o = 0; o < GROUP_NZ_MAX; o++) begin
            w_lane[o] = '0;
        end
        for (int i = 0; i < GROUP_SIZE; i++) begin
            if (bus.in_znz[i]) begin
                w_popcnt = w_popcnt + POP_W'(1);
                if (w_kept < w_limit) begin
                    w_lane[w_kept[LANE_IDX_W-1:0]] = bus.in_act[i*DATA_W +: DATA_W];
                    w_mask[i] = 1'b1;
                    w_kept    = w_kept + POP_W'(1);
                end
            end
        end
        w_violation = (w_popcnt > w_limit);
    end

    generate
        for (genvar g = 0; g < GROUP_NZ_MAX; g++) begin : g_pack
            assign w_act[g*DATA_W +: DATA_W] = w_lane[g];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------------
    logic w_in_ready;
    logic w_accept;
    logic w_out_hs;
    logic w_last_grp;

    // The output register can take a new group when empty or when its current
    // content leaves this cycle, giving one group per cycle throughput.
    assign w_in_ready = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_out_hs   = out_valid_q && bus.out_ready;
    // Compare against len-1 rather than incrementing first, so a maximum
    // frame length never needs grp_cnt to reach 2^FLEN_W.
    assign w_last_grp = (grp_cnt_q == (len_q - FLEN_W'(1)));

    // ------------------------------------------------------------------------
    // Next-state and output-register logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        len_d        = len_q;
        grp_cnt_d    = grp_cnt_q;
        out_valid_d  = out_valid_q;
        out_act_d    = out_act_q;
        out_mask_d   = out_mask_q;
        out_nz_cnt_d = out_nz_cnt_q;
        out_last_d   = out_last_q;
        done_d       = 1'b0;
        err_sticky_d = err_sticky_q;
        err_cnt_d    = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cfg_start) begin
                    mode_d       = bus.cfg_mode;
                    len_d        = bus.cfg_frame_len;
                    grp_cnt_d    = '0;
                    err_sticky_d = 1'b0;
                    err_cnt_d    = '0;
                    if (bus.cfg_frame_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    grp_cnt_d = grp_cnt_q + FLEN_W'(1);
                    if (w_last_grp) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // No accepts here, so the register holds the last beat.
                if (w_out_hs && out_last_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Accepts only happen in RUN, so this never collides with the
        // error clear performed on a start in IDLE.
        if (w_accept) begin
            out_valid_d  = 1'b1;
            out_act_d    = w_act;
            out_mask_d   = w_mask;
            out_nz_cnt_d = NZ_CNT_W'(w_kept);
            out_last_d   = w_last_grp;
            if (w_violation) begin
                err_sticky_d = 1'b1;
                if (err_cnt_q != C_ERR_MAX) begin
                    err_cnt_d = err_cnt_q + FLEN_W'(1);
                end
            end
        end else if (w_out_hs) begin
            out_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= 1'b0;
            len_q        <= '0;
            grp_cnt_q    <= '0;
            out_valid_q  <= 1'b0;
            out_act_q    <= '0;
            out_mask_q   <= '0;
            out_nz_cnt_q <= '0;
            out_last_q   <= 1'b0;
            done_q       <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            len_q        <= len_d;
            grp_cnt_q    <= grp_cnt_d;
            out_valid_q  <= out_valid_d;
            out_act_q    <= out_act_d;
            out_mask_q   <= out_mask_d;
            out_nz_cnt_q <= out_nz_cnt_d;
            out_last_q   <= out_last_d;
            done_q       <= done_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_act    = out_act_q;
    assign bus.out_mask   = out_mask_q;
    assign bus.out_nz_cnt = out_nz_cnt_q;
    assign bus.out_last   = out_last_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = done_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.err_cnt    = err_cnt_q;

endmodule
`default_nettype wire
